// File: rtl/afifo_arb_pkg.sv
// Shared types and default sizing for the async-FIFO write-port arbiter.
package afifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

endpackage

// File: rtl/afifo_rr_pick.sv
// Rotating priority encoder: first set req_valid bit at or above rr_ptr, wrapping.
module afifo_rr_pick
    import afifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx,
    output logic                       pick_any
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        pick_any = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_any && req_valid[idx]) begin
                pick_any = 1'b1;
                pick_idx = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter driving the async FIFO write port.
module afifo_wr_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        wclk,
    input  logic                        wrst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wfull,
    output logic                        winc,
    output logic [DATA_W-1:0]           wdata,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
    output logic                        busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             own_valid;
    logic             own_last;
    logic [DATA_W-1:0] own_data;
    logic             beat;

    afifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .pick_idx  (pick_idx),
        .pick_any  (pick_any)
    );

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat       = 1'b0;
        winc       = 1'b0;
        wdata      = '0;
        req_ready  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                beat  = own_valid & ~wfull;
                winc  = beat;
                wdata = own_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (owner_q == IDW'(i)) & ~wfull;
                end
                // last and burst cap can coincide; both lead to one release
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (own_last || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_id = owner_q;
    assign busy   = (state_q == GRANT);

endmodule

// File: doc/afifo_wr_arbiter.md
# afifo_wr_arbiter

Round-robin arbiter that shares the asynchronous FIFO's write port among NUM_REQ requesters in the write clock domain. Each requester offers bytes on a valid/ready handshake. The block grants one requester at a time, holds the grant for a packet (up to MAX_BURST beats), and drives `winc`/`wdata` into the FIFO while honouring `wfull`. It sits directly in front of the FIFO write side and is the only driver of `winc`.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width; must match the FIFO write data width
- MAX_BURST, 4, maximum beats per grant (1..15)

- wclk  in  1  write-domain clock; all logic on posedge
- wrst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_W  per-requester data, requester i at bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks last beat of a packet
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- wfull  in  1  FIFO full flag (write domain)
- winc  out  1  FIFO write strobe
- wdata  out  DATA_W  FIFO write data
- gnt_id  out  $clog2(NUM_REQ)  current owner index
- busy  out  1  high while in GRANT

## Operation
- State machine with two states: IDLE and GRANT.
- Registers:
  - `owner`: the granted index.
  - `rr_ptr`: the highest-priority index for the next arbitration.
  - `beat_cnt`: width $clog2(MAX_BURST+1).
- IDLE:
  - If any `req_valid` is set, pick the first set bit searching from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - Register the pick as `owner`, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- GRANT:
  - `req_ready[owner] = ~wfull`; all other `req_ready` bits are 0.
  - `winc = req_valid[owner] & ~wfull` (combinational from the registered state).
  - `wdata = req_data[owner]`.
  - A beat occurs when `req_valid[owner] & req_ready[owner]`; each beat increments `beat_cnt`.
- Release:
  - Triggered by a beat with `req_last[owner]=1`, or by a beat where `beat_cnt == MAX_BURST-1`.
  - On release: next state IDLE, `rr_ptr <= (owner+1) mod NUM_REQ`.
- Grant is locked:
  - If the owner drops `req_valid` mid-packet, the grant is held with no timeout.
  - Requests from other requesters are ignored until release.
- `wfull` high in GRANT: no beat, `winc=0`, state and `beat_cnt` unchanged.
- IDLE outputs: `winc=0`, `req_ready=0`, `wdata=0`, `busy=0`; `gnt_id` holds the last owner.

## Timing
- Reset values: state IDLE, `owner=0`, `rr_ptr=0`, `beat_cnt=0`, `winc=0`, `req_ready=0`, `wdata=0`, `gnt_id=0`, `busy=0`.
- Arbitration latency: a `req_valid` seen in IDLE at edge N gives GRANT and a possible first beat in the cycle after edge N.
- Every grant is followed by exactly one IDLE bubble cycle. Back-to-back packets therefore take (beats + 1) cycles each, with no other overhead.
- `wfull` deassertion: a write occurs in the same cycle, since `winc` is combinational from `wfull`.
- Simultaneous requests: only the round-robin winner is granted. `rr_ptr` rotation guarantees each of NUM_REQ continuously-requesting sources a grant within NUM_REQ grants.
- `req_last` on a beat that also reaches MAX_BURST: a single release, with no double rotation.
- Wrap-around: `rr_ptr` at NUM_REQ-1 wraps to 0; the search wraps past index NUM_REQ-1.
- Reset mid-packet: `wrst` forces all state and outputs to reset values immediately (asynchronously). `winc` drops within the same cycle; no partial beat is counted.

## Structure
- Package `afifo_arb_pkg`:
  - State enum `arb_state_e` {IDLE, GRANT}.
  - Default constants for NUM_REQ, DATA_W and MAX_BURST.
- Sub-module `afifo_rr_pick`:
  - Combinational rotating priority encoder.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `pick_idx`, `pick_any`.
- The FSM, counters and output muxing stay in the top level.

## Test plan
- Reset: assert `wrst` mid-burst with `req_valid[2]` high → `winc`, `req_ready`, `busy` go 0 immediately; after release, `gnt_id=0` and `rr_ptr=0`.
- Single requester: req 1 sends 0x11, 0x22, 0x33 with last on 0x33 → three consecutive `winc` pulses carrying 0x11/0x22/0x33, then 1 IDLE cycle, `rr_ptr=2`.
- Round-robin: all 4 request continuously with 1-beat packets → grant order 0, 1, 2, 3, 0, …; each beat separated by 1 bubble.
- Burst cap: req 3 sends 6 beats with no last and MAX_BURST=4 → release after 4th beat, then other requests are served before beats 5–6.
- Full back-pressure: `wfull=1` for 5 cycles during beat 2 → `winc=0`, `req_ready=0`, `beat_cnt` held; write resumes in the same cycle `wfull` falls, with no data lost or duplicated.
- Owner stall: owner drops `req_valid` for 3 cycles mid-packet while req 0 requests → grant held; req 0 is served only after the owner's last beat.
